// File: rtl/dso100fb_pkg.sv
// Shared RGB565 field layout, default transparency key and the 565->888 expansion.
package dso100fb_pkg;
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam logic [15:0] OVERLAY_KEY_DEFAULT = 16'hF81F;

  // Replicate the top bits into the new LSBs so full-scale stays full-scale.
  function automatic logic [23:0] expand_565_888(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[R_MSB:R_LSB];
    g = p[G_MSB:G_LSB];
    b = p[B_MSB:B_LSB];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction
endpackage

// File: rtl/dso100fb_rgb565_expand.sv
// Combinational RGB565 to RGB888 expansion.
module dso100fb_rgb565_expand
  import dso100fb_pkg::*;
(
  input  logic [15:0] pix,
  output logic [23:0] rgb
);
  assign rgb = expand_565_888(pix);
endmodule

// File: rtl/dso100fb_pixout.sv
// Pixel output stage: unpacks FIFO words, applies overlay, registers RGB888 to the panel.
module dso100fb_pixout
  import dso100fb_pkg::*;
#(
  parameter logic [15:0] OVERLAY_KEY = OVERLAY_KEY_DEFAULT,
  parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
  input  logic        VIDCLK,
  input  logic        VID_RST,
  input  logic        VIDEO_FETCH,
  input  logic        READ_RESET,
  input  logic        OVERLAY_EN,
  input  logic [15:0] OVERLAY_DATA,
  input  logic [31:0] FIFO_DATA,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RD,
  output logic [7:0]  VID_R,
  output logic [7:0]  VID_G,
  output logic [7:0]  VID_B,
  output logic        UNDERFLOW,
  output logic [15:0] UNDERFLOW_COUNT
);
  logic        phase;
  logic        slot;
  logic        starve;
  logic        ovl_hit;
  logic [15:0] src565;
  logic [15:0] mux565;
  logic [23:0] exp888;
  logic [23:0] pix888;

  assign slot    = VIDEO_FETCH & ~READ_RESET;
  assign starve  = slot & FIFO_EMPTY;
  assign FIFO_RD = VIDEO_FETCH & phase & ~FIFO_EMPTY & ~READ_RESET & ~VID_RST;

  assign src565  = phase ? FIFO_DATA[31:16] : FIFO_DATA[15:0];
  assign ovl_hit = OVERLAY_EN & (OVERLAY_DATA != OVERLAY_KEY);
  assign mux565  = ovl_hit ? OVERLAY_DATA : src565;

  dso100fb_rgb565_expand u_expand (
    .pix (mux565),
    .rgb (exp888)
  );

  // Overlay still wins over a starved pixel; only the FIFO source is blanked.
  assign pix888 = (FIFO_EMPTY && !ovl_hit) ? BLANK_COLOR : exp888;

  always_ff @(posedge VIDCLK or posedge VID_RST) begin
    if (VID_RST) begin
      phase           <= 1'b0;
      VID_R           <= '0;
      VID_G           <= '0;
      VID_B           <= '0;
      UNDERFLOW       <= 1'b0;
      UNDERFLOW_COUNT <= '0;
    end else begin
      if (READ_RESET)       phase <= 1'b0;
      else if (VIDEO_FETCH) phase <= ~phase;

      {VID_R, VID_G, VID_B} <= slot ? pix888 : 24'h0;
      UNDERFLOW <= starve;
      if (starve && UNDERFLOW_COUNT != 16'hFFFF)
        UNDERFLOW_COUNT <= UNDERFLOW_COUNT + 16'd1;
    end
  end
endmodule

// File: tb/tb_dso100fb_pixout.sv
// Directed bench for dso100fb_pixout with hand-computed expected pixels.
module tb_dso100fb_pixout;
  logic        VIDCLK = 1'b0;
  logic        VID_RST;
  logic        VIDEO_FETCH;
  logic        READ_RESET;
  logic        OVERLAY_EN;
  logic [15:0] OVERLAY_DATA;
  logic [31:0] FIFO_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_RD;
  logic [7:0]  VID_R, VID_G, VID_B;
  logic        UNDERFLOW;
  logic [15:0] UNDERFLOW_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  dso100fb_pixout dut (
    .VIDCLK          (VIDCLK),
    .VID_RST         (VID_RST),
    .VIDEO_FETCH     (VIDEO_FETCH),
    .READ_RESET      (READ_RESET),
    .OVERLAY_EN      (OVERLAY_EN),
    .OVERLAY_DATA    (OVERLAY_DATA),
    .FIFO_DATA       (FIFO_DATA),
    .FIFO_EMPTY      (FIFO_EMPTY),
    .FIFO_RD         (FIFO_RD),
    .VID_R           (VID_R),
    .VID_G           (VID_G),
    .VID_B           (VID_B),
    .UNDERFLOW       (UNDERFLOW),
    .UNDERFLOW_COUNT (UNDERFLOW_COUNT)
  );

  always #5 VIDCLK = ~VIDCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fetch, input logic rr, input logic en,
                       input logic [15:0] od, input logic [31:0] d, input logic emp);
    VIDEO_FETCH  = fetch;
    READ_RESET   = rr;
    OVERLAY_EN   = en;
    OVERLAY_DATA = od;
    FIFO_DATA    = d;
    FIFO_EMPTY   = emp;
  endtask

  // One slot: check the combinational pop before the edge, registered outputs after it.
  task automatic cyc(input string tag, input logic fetch, input logic rr, input logic en,
                     input logic [15:0] od, input logic [31:0] d, input logic emp,
                     input logic exp_rd, input logic [23:0] exp_rgb, input logic exp_uf);
    drive(fetch, rr, en, od, d, emp);
    #1;
    chk({tag, ".rd"}, {31'd0, FIFO_RD}, {31'd0, exp_rd});
    @(posedge VIDCLK); #1;
    chk({tag, ".rgb"}, {8'd0, VID_R, VID_G, VID_B}, {8'd0, exp_rgb});
    chk({tag, ".uf"}, {31'd0, UNDERFLOW}, {31'd0, exp_uf});
  endtask

  initial begin
    VID_RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h07E0_F800, 1'b0);
    #1;
    chk("rst.rgb", {8'd0, VID_R, VID_G, VID_B}, 32'd0);
    chk("rst.uf", {31'd0, UNDERFLOW}, 32'd0);
    chk("rst.cnt", {16'd0, UNDERFLOW_COUNT}, 32'd0);
    chk("rst.rd", {31'd0, FIFO_RD}, 32'd0);
    @(posedge VIDCLK); @(posedge VIDCLK); #1;
    VID_RST = 1'b0;

    // Phase and pop
    cyc("pp1", 1, 0, 0, 16'h0, 32'h07E0_F800, 0, 0, 24'hFF0000, 0);
    cyc("pp2", 1, 0, 0, 16'h0, 32'h07E0_F800, 0, 1, 24'h00FF00, 0);
    cyc("pp3", 1, 0, 0, 16'h0, 32'h001F_FFFF, 0, 0, 24'hFFFFFF, 0);
    cyc("pp4", 1, 0, 0, 16'h0, 32'h001F_FFFF, 0, 1, 24'h0000FF, 0);
    cyc("blank", 0, 0, 0, 16'h0, 32'hFFFF_FFFF, 0, 0, 24'h000000, 0);

    // Underflow: three starved slots leave phase at 1
    cyc("uf1", 1, 0, 0, 16'h0, 32'hFFFF_FFFF, 1, 0, 24'h000000, 1);
    cyc("uf2", 1, 0, 0, 16'h0, 32'hFFFF_FFFF, 1, 0, 24'h000000, 1);
    cyc("uf3", 1, 0, 0, 16'h0, 32'hFFFF_FFFF, 1, 0, 24'h000000, 1);
    chk("uf.cnt", {16'd0, UNDERFLOW_COUNT}, 32'd3);
    cyc("uf.hi", 1, 0, 0, 16'h0, 32'h00FF_0000, 0, 1, 24'h001CFF, 0);
    chk("uf.cnt2", {16'd0, UNDERFLOW_COUNT}, 32'd3);

    // Overlay key transparency
    cyc("ov1", 1, 0, 1, 16'hF81F, 32'hFFFF_FFFF, 0, 0, 24'hFFFFFF, 0);
    cyc("ov2", 1, 0, 1, 16'h001F, 32'hFFFF_FFFF, 0, 1, 24'h0000FF, 0);
    cyc("ov3", 1, 0, 1, 16'hF81F, 32'hFFFF_FFFF, 0, 0, 24'hFFFFFF, 0);
    cyc("ov4", 1, 0, 1, 16'h001F, 32'hFFFF_FFFF, 0, 1, 24'h0000FF, 0);
    cyc("ov.uf", 1, 0, 1, 16'h07E0, 32'hFFFF_FFFF, 1, 0, 24'h00FF00, 1);
    cyc("ov.ufkey", 1, 0, 1, 16'hF81F, 32'hFFFF_FFFF, 1, 0, 24'h000000, 1);
    chk("ov.cnt", {16'd0, UNDERFLOW_COUNT}, 32'd5);
    cyc("ov.p1", 1, 0, 0, 16'h0, 32'hFFFF_FFFF, 0, 0, 24'hFFFFFF, 0);

    // READ_RESET with phase=1 and fetch active
    cyc("rr1", 1, 1, 0, 16'h0, 32'hFFFF_FFFF, 0, 0, 24'h000000, 0);
    cyc("rr2", 1, 1, 0, 16'h0, 32'hFFFF_FFFF, 1, 0, 24'h000000, 0);
    chk("rr.cnt", {16'd0, UNDERFLOW_COUNT}, 32'd5);
    cyc("rr.p0", 1, 0, 0, 16'h0, 32'h07E0_F800, 0, 0, 24'hFF0000, 0);

    // Async reset mid-line with phase=1
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h07E0_F800, 1'b0);
    #1;
    chk("ar.rd_pre", {31'd0, FIFO_RD}, 32'd1);
    #2 VID_RST = 1'b1;
    #1;
    chk("ar.rgb", {8'd0, VID_R, VID_G, VID_B}, 32'd0);
    chk("ar.cnt", {16'd0, UNDERFLOW_COUNT}, 32'd0);
    chk("ar.rd", {31'd0, FIFO_RD}, 32'd0);
    @(posedge VIDCLK); #1;
    VID_RST = 1'b0;
    cyc("ar.p0", 1, 0, 0, 16'h0, 32'h07E0_F800, 0, 0, 24'hFF0000, 0);

    // Saturation: run the count up to FFFE, then three more starved slots
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    for (int i = 0; i < 65534; i++) @(posedge VIDCLK);
    #1;
    chk("sat.pre", {16'd0, UNDERFLOW_COUNT}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      cyc("sat", 1, 0, 0, 16'h0, 32'h0, 1, 0, 24'h000000, 1);
      chk("sat.cnt", {16'd0, UNDERFLOW_COUNT}, 32'hFFFF);
    end
    cyc("sat.idle", 0, 0, 0, 16'h0, 32'h0, 1, 0, 24'h000000, 0);
    chk("sat.hold", {16'd0, UNDERFLOW_COUNT}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
